// File: rtl/qspi_pkg.sv
// Shared types, beat constants and phase-selection helpers for the QSPI phase sequencer.
// The helpers are pure functions so the sequencer and any reference model agree on ordering.
package qspi_pkg;

    typedef enum logic [2:0] {
        PH_IDLE,
        PH_SETUP,
        PH_CMD,
        PH_ADDR,
        PH_MODE,
        PH_DUMMY,
        PH_DATA,
        PH_HOLD
    } phase_e;

    localparam int CMD_BEATS_1L  = 8;
    localparam int CMD_BEATS_4L  = 2;
    localparam int ADDR_BEATS_24 = 6;
    localparam int ADDR_BEATS_32 = 8;
    localparam int MODE_BEATS    = 2;

    typedef struct packed {
        logic       cmd_en;
        logic       cmd_quad;
        logic       addr_en;
        logic       addr_4b;
        logic       mode_en;
        logic [3:0] dummy_cycles;
        logic       data_en;
        logic [3:0] data_beats_m1;
        logic       xip_en;
    } desc_t;

    function automatic logic is_counted(phase_e p);
        return (p == PH_CMD) || (p == PH_ADDR) || (p == PH_MODE) ||
               (p == PH_DUMMY) || (p == PH_DATA);
    endfunction

    function automatic logic phase_enabled(phase_e p, desc_t d);
        logic en;
        en = 1'b0;
        case (p)
            PH_CMD:   en = d.cmd_en & ~d.xip_en;
            PH_ADDR:  en = d.addr_en;
            PH_MODE:  en = d.mode_en;
            PH_DUMMY: en = (d.dummy_cycles != 4'd0);
            PH_DATA:  en = d.data_en;
            default:  en = 1'b0;
        endcase
        return en;
    endfunction

    // Later phases are tested first so the earliest enabled phase after cur wins.
    function automatic phase_e next_phase(phase_e cur, desc_t d);
        phase_e nxt;
        nxt = PH_HOLD;
        if ((cur < PH_DATA)  && phase_enabled(PH_DATA, d))  nxt = PH_DATA;
        if ((cur < PH_DUMMY) && phase_enabled(PH_DUMMY, d)) nxt = PH_DUMMY;
        if ((cur < PH_MODE)  && phase_enabled(PH_MODE, d))  nxt = PH_MODE;
        if ((cur < PH_ADDR)  && phase_enabled(PH_ADDR, d))  nxt = PH_ADDR;
        if ((cur < PH_CMD)   && phase_enabled(PH_CMD, d))   nxt = PH_CMD;
        return nxt;
    endfunction

    function automatic logic [3:0] phase_target(phase_e p, desc_t d);
        logic [3:0] t;
        t = 4'd0;
        case (p)
            PH_CMD:   t = d.cmd_quad ? 4'(CMD_BEATS_4L - 1) : 4'(CMD_BEATS_1L - 1);
            PH_ADDR:  t = d.addr_4b ? 4'(ADDR_BEATS_32 - 1) : 4'(ADDR_BEATS_24 - 1);
            PH_MODE:  t = 4'(MODE_BEATS - 1);
            PH_DUMMY: t = d.dummy_cycles - 4'd1;
            PH_DATA:  t = d.data_beats_m1;
            default:  t = 4'd0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/qspi_phase_seq_if.sv
// Descriptor request channel from the AHB-side front end to the phase sequencer.
// Handshake: a descriptor transfers on the clock edge where req_valid and req_ready are both high.
interface qspi_phase_seq_if;
    logic       req_valid;
    logic       req_ready;
    logic       cmd_en;
    logic       cmd_quad;
    logic       addr_en;
    logic       addr_4b;
    logic       mode_en;
    logic [3:0] dummy_cycles;
    logic       data_en;
    logic [3:0] data_beats_m1;
    logic       xip_en;

    modport master (
        output req_valid, cmd_en, cmd_quad, addr_en, addr_4b, mode_en,
               dummy_cycles, data_en, data_beats_m1, xip_en,
        input  req_ready
    );

    modport slave (
        input  req_valid, cmd_en, cmd_quad, addr_en, addr_4b, mode_en,
               dummy_cycles, data_en, data_beats_m1, xip_en,
        output req_ready
    );
endinterface

// File: rtl/qspi_phase_seq.sv
// Walks one QSPI flash frame (CS setup, counted phases, CS hold) per accepted descriptor,
// steering the external beat counter and driving cs_n; phase doubles as the FSM state.
module qspi_phase_seq
    import qspi_pkg::*;
#(
    parameter int SETUP_CYCLES = 1,
    parameter int HOLD_CYCLES  = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    qspi_phase_seq_if.slave         req,
    output phase_e                  phase,
    output logic                    start_count,
    output logic [3:0]              target_count,
    output logic                    xip_field_out,
    input  logic                    count_done,
    output logic                    cs_n,
    output logic                    busy,
    output logic                    done
);

    localparam logic [3:0] SETUP_LOAD = 4'(SETUP_CYCLES - 1);
    localparam logic [3:0] HOLD_LOAD  = 4'(HOLD_CYCLES - 1);

    phase_e     state_q, state_d;
    logic [3:0] timer_q, timer_d;
    desc_t      desc_q, desc_d;
    logic       ready_q, ready_d;
    logic       start_d, xip_d, cs_n_d, busy_d, done_d;
    logic [3:0] target_d;

    assign phase         = state_q;
    assign req.req_ready = ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= PH_IDLE;
            timer_q       <= 4'd0;
            desc_q        <= '0;
            ready_q       <= 1'b1;
            start_count   <= 1'b0;
            target_count  <= 4'd0;
            xip_field_out <= 1'b0;
            cs_n          <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            desc_q        <= desc_d;
            ready_q       <= ready_d;
            start_count   <= start_d;
            target_count  <= target_d;
            xip_field_out <= xip_d;
            cs_n          <= cs_n_d;
            busy          <= busy_d;
            done          <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        desc_d  = desc_q;
        xip_d   = xip_field_out;
        done_d  = 1'b0;

        case (state_q)
            PH_IDLE: begin
                if (req.req_valid && ready_q) begin
                    desc_d = '{cmd_en:        req.cmd_en,
                               cmd_quad:      req.cmd_quad,
                               addr_en:       req.addr_en,
                               addr_4b:       req.addr_4b,
                               mode_en:       req.mode_en,
                               dummy_cycles:  req.dummy_cycles,
                               data_en:       req.data_en,
                               data_beats_m1: req.data_beats_m1,
                               xip_en:        req.xip_en};
                    xip_d   = req.xip_en;
                    timer_d = SETUP_LOAD;
                    state_d = PH_SETUP;
                end
            end
            PH_SETUP: begin
                if (timer_q == 4'd0) begin
                    state_d = next_phase(PH_SETUP, desc_q);
                    if (state_d == PH_HOLD) timer_d = HOLD_LOAD;
                end else begin
                    timer_d = timer_q - 4'd1;
                end
            end
            PH_HOLD: begin
                if (timer_q == 4'd0) begin
                    state_d = PH_IDLE;
                    done_d  = 1'b1;
                end else begin
                    timer_d = timer_q - 4'd1;
                end
            end
            default: begin
                // Counted phases: the beat counter paces us via count_done.
                if (count_done) begin
                    state_d = next_phase(state_q, desc_q);
                    if (state_d == PH_HOLD) timer_d = HOLD_LOAD;
                end
            end
        endcase

        // Counter controls are derived from the next state so they change on the same edge.
        start_d  = is_counted(state_d);
        target_d = start_d ? phase_target(state_d, desc_d) : 4'd0;
        cs_n_d   = (state_d == PH_IDLE);
        busy_d   = (state_d != PH_IDLE);
        ready_d  = (state_d == PH_IDLE);
    end

endmodule
